mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, 1-cycle-read-latency word memory between the core's instruction-fetch port and its load/store port.
- Lets a unified instruction/data memory replace the split insn_memory/data_memory pair.
- Load/store has priority over fetch; a starvation counter guarantees fetch forward progress.
- Sits between the core datapath (PC/fetch and MEM stage) and the memory macro; both requesters stall until granted.

Parameters:
- AW, 10, memory word-address width (1024 words).
- MAX_LS_RUN, 4, maximum consecutive load/store grants while a fetch is pending (range 1..15).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch data valid (cycle after grant)
- if_rdata  out  32  fetched instruction
- ls_req  in  1  load/store request; held until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_be  in  4  store byte enables
- ls_addr  in  32  load/store byte address
- ls_wdata  in  32  store data
- ls_gnt  out  1  load/store accepted this cycle (combinational)
- ls_rvalid  out  1  load data valid, or store acknowledge (cycle after grant)
- ls_rdata  out  32  load data; 0 on store acknowledge
- mem_en  out  1  memory access this cycle
- mem_we  out  4  per-byte write strobes
- mem_addr  out  AW  word address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid the cycle after mem_en with mem_we = 0

Behaviour:
- Reset (reset = 0, asynchronous):
  - owner = NONE, ls_run = 0.
  - All rvalid outputs 0; rdata outputs 0.
  - All grants 0 while reset is asserted. mem_en and mem_we are forced 0.
- Grant decision, combinational, every cycle:
  - Fetch wins if if_req && (!ls_req || ls_run == MAX_LS_RUN).
  - Otherwise load/store wins if ls_req.
  - At most one grant per cycle.
- The winner drives the memory in the same cycle:
  - mem_en = 1; mem_addr = addr[AW+1:2].
  - Address bits [1:0] are ignored; bits above AW+1 are ignored (wrap).
  - mem_we = ls_be if load/store wins with ls_we = 1; otherwise 0.
  - mem_wdata = ls_wdata.
- owner register (FSM, states NONE / IF / LS / LS_WR): loads the winner each cycle, or NONE if nobody is granted.
- Response, one cycle after grant:
  - owner = IF: if_rvalid = 1, if_rdata = mem_rdata.
  - owner = LS: ls_rvalid = 1, ls_rdata = mem_rdata.
  - owner = LS_WR: ls_rvalid = 1, ls_rdata = 0.
  - rdata outputs are 0 whenever the matching rvalid = 0.
- Fixed latency is 1 cycle. Back-to-back grants are allowed every cycle (fully pipelined, no bubble).
- A requester may present a new request in the same cycle its rvalid arrives.
- Starvation counter ls_run (4 bits):
  - Increments on each ls grant while if_req = 1.
  - Cleared on a fetch grant or when if_req = 0.
  - Saturates at MAX_LS_RUN.
- Simultaneous requests with ls_run < MAX_LS_RUN: load/store granted, fetch stalls (if_gnt = 0).
- Requests dropped before grant: ignored, no state change.
- Reset asserted mid-access: the pending response is discarded; no rvalid after reset release.

Decomposition:
- Shared package (core_pkg) holds owner encoding constants: OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_LS = 2'd2, OWN_LS_WR = 2'd3.
- Shared package also holds the default MEM_AW = 10.
- No sub-module; the counter and FSM are small enough to stay inline.

Test Plan:
- Fetch only: if_req = 1, if_addr = 0x4, mem word[1] = 0x00405113 -> if_gnt same cycle, mem_addr = 1; next cycle if_rvalid = 1, if_rdata = 0x00405113.
- Contention: if_req and ls_req both held, load at 0x10, fetch at 0x0 -> ls_gnt in cycles 0..3, if_gnt in cycle 4, ls_gnt resumes in cycle 5 (MAX_LS_RUN = 4).
- Byte store then load: store ls_be = 4'b0010, ls_wdata = 0x0000AB00 to 0x20 (word pre = 0x11223344) -> mem_we = 4'b0010, ls_rvalid with ls_rdata = 0; next load of 0x20 returns 0x1122AB44.
- Back-to-back fetches at 0x0, 0x4, 0x8 on consecutive cycles -> three consecutive if_rvalid pulses, data in order, no bubbles.
- Address wrap: ls_addr = 0x00001004 (AW = 10) -> mem_addr = 1.
- Reset mid-access: grant fetch, assert reset = 0 before the next edge -> if_rvalid stays 0, owner = NONE, mem_en = 0 while reset is low; normal operation after release.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the unified instruction/data memory path:
// owner encodings for the memory port arbiter and the default word-address width.
package core_pkg;

  localparam int unsigned MEM_AW = 10;

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_IF    = 2'd1;
  localparam logic [1:0] OWN_LS    = 2'd2;
  localparam logic [1:0] OWN_LS_WR = 2'd3;

  typedef enum logic [1:0] {
    OwnNone = OWN_NONE,
    OwnIf   = OWN_IF,
    OwnLs   = OWN_LS,
    OwnLsWr = OWN_LS_WR
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-macro signals around the shared memory port.
// The core and memory model drive the master side; the arbiter sits on the slave side.
interface mem_port_arbiter_if import core_pkg::*; #(
  parameter int unsigned AW = MEM_AW
);
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;

  logic          ls_req;
  logic          ls_we;
  logic [3:0]    ls_be;
  logic [31:0]   ls_addr;
  logic [31:0]   ls_wdata;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [31:0]   ls_rdata;

  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, 1-cycle-latency memory between fetch and load/store.
// Load/store has priority; a bounded run counter guarantees fetch progress.
module mem_port_arbiter import core_pkg::*; #(
  parameter int unsigned AW         = MEM_AW,
  parameter int unsigned MAX_LS_RUN = 4
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] MaxRun = 4'(MAX_LS_RUN);

  owner_e     owner_q, owner_d;
  logic [3:0] ls_run_q, ls_run_d;
  logic       if_win, ls_win;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q  <= OwnNone;
      ls_run_q <= 4'd0;
    end else begin
      owner_q  <= owner_d;
      ls_run_q <= ls_run_d;
    end
  end

  always_comb begin
    if_win   = 1'b0;
    ls_win   = 1'b0;
    owner_d  = OwnNone;
    ls_run_d = ls_run_q;

    // Gating with reset keeps grants and memory strobes low while reset is held.
    if (reset) begin
      if_win = bus.if_req && (!bus.ls_req || ls_run_q == MaxRun);
      ls_win = bus.ls_req && !if_win;
    end

    if (if_win) begin
      owner_d = OwnIf;
    end else if (ls_win) begin
      owner_d = bus.ls_we ? OwnLsWr : OwnLs;
    end

    if (!bus.if_req || if_win) begin
      ls_run_d = 4'd0;
    end else if (ls_win && ls_run_q != MaxRun) begin
      ls_run_d = ls_run_q + 4'd1;
    end

    bus.if_gnt    = if_win;
    bus.ls_gnt    = ls_win;
    bus.mem_en    = if_win || ls_win;
    bus.mem_addr  = if_win ? bus.if_addr[AW+1:2] : bus.ls_addr[AW+1:2];
    bus.mem_we    = (ls_win && bus.ls_we) ? bus.ls_be : 4'b0000;
    bus.mem_wdata = bus.ls_wdata;

    bus.if_rvalid = (owner_q == OwnIf);
    bus.if_rdata  = (owner_q == OwnIf) ? bus.mem_rdata : 32'd0;
    bus.ls_rvalid = (owner_q == OwnLs) || (owner_q == OwnLsWr);
    bus.ls_rdata  = (owner_q == OwnLs) ? bus.mem_rdata : 32'd0;
  end

  // Byte-offset and wrap-around address bits are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^{bus.if_addr[31:AW+2], bus.if_addr[1:0],
                         bus.ls_addr[31:AW+2], bus.ls_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-writable 1-cycle-latency memory model.
module tb_mem_port_arbiter;
  import core_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  mem_port_arbiter_if #(.AW(10)) bus ();

  mem_port_arbiter #(.AW(10), .MAX_LS_RUN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] mem [1024];
  logic [31:0] rdata_q;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
      rdata_q <= mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = rdata_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'd0;
    bus.ls_req   = 1'b0;
    bus.ls_we    = 1'b0;
    bus.ls_be    = 4'b0000;
    bus.ls_addr  = 32'd0;
    bus.ls_wdata = 32'd0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] data);
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_be    = be;
    bus.ls_addr  = addr;
    bus.ls_wdata = data;
    step();
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    bus.if_req = 1'b1;
    bus.ls_req = 1'b1;
    #3;
    n_checks++; if (bus.if_gnt !== 1'b0) $display("FAIL rst_if_gnt: got %b want 0", bus.if_gnt); else n_pass++;
    n_checks++; if (bus.ls_gnt !== 1'b0) $display("FAIL rst_ls_gnt: got %b want 0", bus.ls_gnt); else n_pass++;
    n_checks++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 4'b0) $display("FAIL rst_mem: en %b we %b want 0 0", bus.mem_en, bus.mem_we); else n_pass++;
    n_checks++; if (bus.if_rvalid !== 1'b0 || bus.ls_rvalid !== 1'b0) $display("FAIL rst_rvalid: if %b ls %b want 0 0", bus.if_rvalid, bus.ls_rvalid); else n_pass++;
    n_checks++; if (bus.if_rdata !== 32'd0 || bus.ls_rdata !== 32'd0) $display("FAIL rst_rdata: if %h ls %h want 0 0", bus.if_rdata, bus.ls_rdata); else n_pass++;
    idle();
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic preload();
    do_store(32'h0000_0000, 4'b1111, 32'h0000_0013);
    do_store(32'h0000_0004, 4'b1111, 32'h0040_5113);
    do_store(32'h0000_0008, 4'b1111, 32'h00a0_0093);
    do_store(32'h0000_0010, 4'b1111, 32'hDEAD_BEEF);
    do_store(32'h0000_0020, 4'b1111, 32'h1122_3344);
    step();
  endtask

  task automatic test_fetch();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h4;
    #1;
    n_checks++; if (bus.if_gnt !== 1'b1 || bus.ls_gnt !== 1'b0) $display("FAIL fetch_gnt: if %b ls %b want 1 0", bus.if_gnt, bus.ls_gnt); else n_pass++;
    n_checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 10'd1 || bus.mem_we !== 4'b0) $display("FAIL fetch_mem: en %b addr %0d we %b want 1 1 0000", bus.mem_en, bus.mem_addr, bus.mem_we); else n_pass++;
    step();
    idle();
    #1;
    n_checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h0040_5113) $display("FAIL fetch_resp: rvalid %b data %h want 1 00405113", bus.if_rvalid, bus.if_rdata); else n_pass++;
    n_checks++; if (bus.ls_rvalid !== 1'b0) $display("FAIL fetch_ls_quiet: ls_rvalid %b want 0", bus.ls_rvalid); else n_pass++;
    step();
  endtask

  task automatic test_contention();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0;
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_addr = 32'h10;
    for (int c = 0; c < 6; c++) begin
      logic exp_if;
      exp_if = (c == 4);
      #1;
      n_checks++;
      if (bus.if_gnt !== exp_if || bus.ls_gnt !== !exp_if)
        $display("FAIL contention_gnt c%0d: if %b ls %b want %b %b", c, bus.if_gnt, bus.ls_gnt, exp_if, !exp_if);
      else n_pass++;
      if (c == 1) begin
        n_checks++; if (bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== 32'hDEAD_BEEF) $display("FAIL contention_load: rvalid %b data %h want 1 deadbeef", bus.ls_rvalid, bus.ls_rdata); else n_pass++;
      end
      if (c == 5) begin
        n_checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h0000_0013 || bus.ls_rvalid !== 1'b0) $display("FAIL contention_fetch: if_rvalid %b data %h ls_rvalid %b want 1 00000013 0", bus.if_rvalid, bus.if_rdata, bus.ls_rvalid); else n_pass++;
      end
      @(posedge clk);
    end
    #1;
    idle();
    step();
    step();
  endtask

  task automatic test_byte_store();
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_be    = 4'b0010;
    bus.ls_addr  = 32'h20;
    bus.ls_wdata = 32'h0000_AB00;
    #1;
    n_checks++; if (bus.ls_gnt !== 1'b1 || bus.mem_we !== 4'b0010 || bus.mem_addr !== 10'd8) $display("FAIL store_mem: gnt %b we %b addr %0d want 1 0010 8", bus.ls_gnt, bus.mem_we, bus.mem_addr); else n_pass++;
    step();
    bus.ls_we = 1'b0;
    bus.ls_be = 4'b0000;
    #1;
    n_checks++; if (bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== 32'd0) $display("FAIL store_ack: rvalid %b data %h want 1 0", bus.ls_rvalid, bus.ls_rdata); else n_pass++;
    n_checks++; if (bus.ls_gnt !== 1'b1 || bus.mem_we !== 4'b0) $display("FAIL store_then_load_gnt: gnt %b we %b want 1 0000", bus.ls_gnt, bus.mem_we); else n_pass++;
    step();
    idle();
    #1;
    n_checks++; if (bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== 32'h1122_AB44) $display("FAIL store_readback: rvalid %b data %h want 1 1122ab44", bus.ls_rvalid, bus.ls_rdata); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data [3];
    exp_data[0] = 32'h0000_0013;
    exp_data[1] = 32'h0040_5113;
    exp_data[2] = 32'h00a0_0093;
    bus.if_req  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c < 3) bus.if_addr = 32'(c * 4);
      else idle();
      #1;
      if (c < 3) begin
        n_checks++; if (bus.if_gnt !== 1'b1 || bus.mem_addr !== 10'(c)) $display("FAIL b2b_gnt c%0d: gnt %b addr %0d want 1 %0d", c, bus.if_gnt, bus.mem_addr, c); else n_pass++;
      end
      if (c > 0) begin
        n_checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== exp_data[c-1]) $display("FAIL b2b_resp c%0d: rvalid %b data %h want 1 %h", c, bus.if_rvalid, bus.if_rdata, exp_data[c-1]); else n_pass++;
      end
      step();
    end
    n_checks++; if (bus.if_rvalid !== 1'b0) $display("FAIL b2b_end: rvalid %b want 0", bus.if_rvalid); else n_pass++;
  endtask

  task automatic test_wrap();
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_addr = 32'h0000_1004;
    #1;
    n_checks++; if (bus.ls_gnt !== 1'b1 || bus.mem_addr !== 10'd1) $display("FAIL wrap_addr: gnt %b addr %0d want 1 1", bus.ls_gnt, bus.mem_addr); else n_pass++;
    step();
    idle();
    #1;
    n_checks++; if (bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== 32'h0040_5113) $display("FAIL wrap_data: rvalid %b data %h want 1 00405113", bus.ls_rvalid, bus.ls_rdata); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h4;
    #1;
    n_checks++; if (bus.if_gnt !== 1'b1) $display("FAIL midrst_pre_gnt: gnt %b want 1", bus.if_gnt); else n_pass++;
    #1;
    reset = 1'b0;
    #1;
    n_checks++; if (bus.if_gnt !== 1'b0 || bus.mem_en !== 1'b0) $display("FAIL midrst_gated: gnt %b en %b want 0 0", bus.if_gnt, bus.mem_en); else n_pass++;
    step();
    n_checks++; if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'd0 || bus.mem_en !== 1'b0) $display("FAIL midrst_held: rvalid %b data %h en %b want 0 0 0", bus.if_rvalid, bus.if_rdata, bus.mem_en); else n_pass++;
    idle();
    reset = 1'b1;
    step();
    n_checks++; if (bus.if_rvalid !== 1'b0 || bus.ls_rvalid !== 1'b0) $display("FAIL midrst_release: if %b ls %b want 0 0", bus.if_rvalid, bus.ls_rvalid); else n_pass++;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h8;
    #1;
    n_checks++; if (bus.if_gnt !== 1'b1 || bus.mem_addr !== 10'd2) $display("FAIL midrst_resume_gnt: gnt %b addr %0d want 1 2", bus.if_gnt, bus.mem_addr); else n_pass++;
    step();
    idle();
    #1;
    n_checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h00a0_0093) $display("FAIL midrst_resume_data: rvalid %b data %h want 1 00a00093", bus.if_rvalid, bus.if_rdata); else n_pass++;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    preload();
    test_fetch();
    test_contention();
    test_byte_store();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
